// File: rtl/event_filter_seq.sv
// rtl/event_filter_seq.sv - byte-stream event sequencer around the event filter datapath
module event_filter_seq #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_strb,
    input  logic             in_sof,
    output logic [7:0]       flt_x,
    output logic [7:0]       flt_y,
    output logic [7:0]       flt_p,
    output logic [7:0]       flt_t,
    output logic             flt_valid,
    input  logic             flt_ready,
    input  logic             flt_done,
    input  logic             flt_pass,
    input  logic [7:0]       flt_x_o,
    input  logic [7:0]       flt_y_o,
    input  logic [7:0]       flt_p_o,
    input  logic [7:0]       flt_t_o,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_sof,
    input  logic             out_ready,
    input  logic             clr,
    output logic             busy,
    output logic             overrun,
    output logic             timeout_err,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_EMIT    = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYC);

    state_t     state_q, state_d;
    logic [1:0] idx_q;
    logic [7:0] tcnt_q;
    logic [7:0] tcnt_next;
    logic [7:0] out_x, out_y, out_p, out_t;

    logic store_t, accept, tmo, pass_ev, drop_ev, emit_last;

    assign tcnt_next = tcnt_q + 8'd1;
    assign store_t   = (state_q == ST_COLLECT) && in_strb && !in_sof && (idx_q == 2'd3);
    assign accept    = (state_q == ST_ISSUE) && flt_ready;
    // A verdict arriving on the timeout cycle takes priority over the timeout.
    assign tmo       = (state_q == ST_WAIT) && !flt_done && (tcnt_next == TMO_LIMIT);
    assign pass_ev   = (state_q == ST_WAIT) && flt_done && flt_pass;
    assign drop_ev   = (state_q == ST_WAIT) && ((flt_done && !flt_pass) || tmo);
    assign emit_last = (state_q == ST_EMIT) && out_ready && (idx_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_COLLECT: if (store_t) state_d = ST_ISSUE;
            ST_ISSUE:   if (accept) state_d = ST_WAIT;
            ST_WAIT: begin
                if (pass_ev)      state_d = ST_EMIT;
                else if (drop_ev) state_d = ST_COLLECT;
            end
            ST_EMIT:    if (emit_last) state_d = ST_COLLECT;
            default:    state_d = ST_COLLECT;
        endcase
    end

    always_comb begin
        flt_valid = (state_q == ST_ISSUE);
        out_valid = (state_q == ST_EMIT);
        out_sof   = (state_q == ST_EMIT) && (idx_q == 2'd0);
        busy      = (state_q != ST_COLLECT) || (idx_q != 2'd0);
        out_data  = 8'h00;
        if (state_q == ST_EMIT) begin
            case (idx_q)
                2'd0:    out_data = out_x;
                2'd1:    out_data = out_y;
                2'd2:    out_data = out_p;
                default: out_data = out_t;
            endcase
        end
    end

    // Byte index serves both input assembly and output serialization.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 2'd0;
            flt_x <= 8'h00;
            flt_y <= 8'h00;
            flt_p <= 8'h00;
            flt_t <= 8'h00;
        end else if (state_q == ST_COLLECT && in_strb) begin
            if (in_sof) begin
                flt_x <= in_data;
                idx_q <= 2'd1;
            end else if (idx_q != 2'd0) begin
                case (idx_q)
                    2'd1:    flt_y <= in_data;
                    2'd2:    flt_p <= in_data;
                    default: flt_t <= in_data;
                endcase
                idx_q <= idx_q + 2'd1;
            end
        end else if (state_q == ST_EMIT && out_ready) begin
            idx_q <= idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= 8'h00;
            out_x  <= 8'h00;
            out_y  <= 8'h00;
            out_p  <= 8'h00;
            out_t  <= 8'h00;
        end else begin
            if (accept) begin
                tcnt_q <= 8'h00;
            end else if (state_q == ST_WAIT) begin
                tcnt_q <= tcnt_next;
            end
            if (pass_ev) begin
                out_x <= flt_x_o;
                out_y <= flt_y_o;
                out_p <= flt_p_o;
                out_t <= flt_t_o;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt    <= '0;
            drop_cnt    <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else if (clr) begin
            pass_cnt    <= '0;
            drop_cnt    <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (pass_ev && pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
            if (drop_ev && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
            if (in_strb && state_q != ST_COLLECT) overrun <= 1'b1;
            if (tmo) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_event_filter_seq.sv
// tb/tb_event_filter_seq.sv - scoreboard bench for event_filter_seq
module tb_event_filter_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_strb, in_sof;
    logic [7:0] flt_x, flt_y, flt_p, flt_t;
    logic       flt_valid, flt_ready, flt_done, flt_pass;
    logic [7:0] flt_x_o, flt_y_o, flt_p_o, flt_t_o;
    logic [7:0] out_data;
    logic       out_valid, out_sof, out_ready, clr;
    logic       busy, overrun, timeout_err;
    logic [7:0] pass_cnt, drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];
    logic       done_en = 1'b1;
    logic       pass_en = 1'b1;

    event_filter_seq #(.TIMEOUT_CYC(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_strb(in_strb), .in_sof(in_sof),
        .flt_x(flt_x), .flt_y(flt_y), .flt_p(flt_p), .flt_t(flt_t),
        .flt_valid(flt_valid), .flt_ready(flt_ready),
        .flt_done(flt_done), .flt_pass(flt_pass),
        .flt_x_o(flt_x_o), .flt_y_o(flt_y_o), .flt_p_o(flt_p_o), .flt_t_o(flt_t_o),
        .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_ready(out_ready),
        .clr(clr), .busy(busy), .overrun(overrun), .timeout_err(timeout_err),
        .pass_cnt(pass_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Filter model: verdict one cycle after acceptance, echoing the fields.
    initial begin
        flt_done = 1'b0;
        flt_pass = 1'b0;
        {flt_x_o, flt_y_o, flt_p_o, flt_t_o} = 32'h0;
        forever begin
            @(negedge clk);
            if (flt_valid && flt_ready) begin
                {flt_x_o, flt_y_o, flt_p_o, flt_t_o} = {flt_x, flt_y, flt_p, flt_t};
                @(posedge clk); #1;
                flt_done = done_en;
                flt_pass = pass_en;
                @(posedge clk); #1;
                flt_done = 1'b0;
                flt_pass = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                check("out_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("out_byte", {23'd0, out_sof, out_data}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic strobe(input logic [7:0] b, input logic sof);
        in_data = b;
        in_strb = 1'b1;
        in_sof  = sof;
        @(posedge clk); #1;
        in_strb = 1'b0;
        in_sof  = 1'b0;
    endtask

    task automatic send_event(input logic [7:0] x, input logic [7:0] y,
                              input logic [7:0] p, input logic [7:0] t);
        if (done_en && pass_en) begin
            exp_q.push_back({1'b1, x});
            exp_q.push_back({1'b0, y});
            exp_q.push_back({1'b0, p});
            exp_q.push_back({1'b0, t});
        end
        strobe(x, 1'b1);
        strobe(y, 1'b0);
        strobe(p, 1'b0);
        strobe(t, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || out_valid) && n < 200);
        check(tag, 32'(n < 200), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_data = 8'h00; in_strb = 1'b0; in_sof = 1'b0;
        flt_ready = 1'b1; out_ready = 1'b1; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flt_valid", 32'(flt_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnts", {16'd0, pass_cnt, drop_cnt}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic pass with latency check
        strobe(8'h12, 1'b1);
        strobe(8'h34, 1'b0);
        strobe(8'h01, 1'b0);
        check("pre_t_flt_valid", 32'(flt_valid), 32'd0);
        exp_q.push_back(9'h112); exp_q.push_back(9'h034);
        exp_q.push_back(9'h001); exp_q.push_back(9'h07F);
        strobe(8'h7F, 1'b0);
        check("latency_flt_valid", 32'(flt_valid), 32'd1);
        check("flt_fields", {flt_x, flt_y, flt_p, flt_t}, 32'h1234017F);
        wait_idle("idle_pass");
        check("pass_cnt_1", 32'(pass_cnt), 32'd1);
        check("queue_drained_1", 32'(exp_q.size()), 32'd0);

        // Drop verdict
        pass_en = 1'b0;
        send_event(8'h12, 8'h34, 8'h01, 8'h7F);
        wait_idle("idle_drop");
        check("drop_cnt_1", 32'(drop_cnt), 32'd1);
        check("busy_after_drop", 32'(busy), 32'd0);
        pass_en = 1'b1;

        // Timeout
        done_en = 1'b0;
        send_event(8'h21, 8'h22, 8'h23, 8'h24);
        @(posedge clk); #1;
        check("wait_busy", 32'(busy), 32'd1);
        repeat (15) @(posedge clk);
        #1;
        check("tmo_not_yet", 32'(timeout_err), 32'd0);
        @(posedge clk); #1;
        check("tmo_set", 32'(timeout_err), 32'd1);
        check("tmo_drop_cnt", 32'(drop_cnt), 32'd2);
        done_en = 1'b1;
        wait_idle("idle_tmo");
        send_event(8'h5A, 8'h5B, 8'h5C, 8'h5D);
        wait_idle("idle_after_tmo");
        check("pass_cnt_2", 32'(pass_cnt), 32'd2);

        // Resync on a new sof
        strobe(8'hAA, 1'b1);
        strobe(8'hBB, 1'b0);
        send_event(8'h11, 8'h22, 8'h33, 8'h44);
        check("resync_fields", {flt_x, flt_y, flt_p, flt_t}, 32'h11223344);
        wait_idle("idle_resync");

        // Backpressure during EMIT plus overrun
        out_ready = 1'b0;
        send_event(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("emit_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                in_data = 8'h55; in_strb = 1'b1;
            end
            @(posedge clk); #1;
            in_strb = 1'b0;
            check("hold_data", {23'd0, out_sof, out_data}, 32'h1A0);
        end
        check("overrun_set", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        wait_idle("idle_emit");
        check("queue_drained_2", 32'(exp_q.size()), 32'd0);
        pulse_clr();
        check("clr_flags", {30'd0, overrun, timeout_err}, 32'd0);
        check("clr_cnts", {16'd0, pass_cnt, drop_cnt}, 32'd0);

        // Saturation
        pass_en = 1'b0;
        for (int i = 0; i < 300; i++) begin
            send_event(8'(i), 8'h01, 8'h02, 8'h03);
            wait_idle("idle_sat");
        end
        check("drop_sat", 32'(drop_cnt), 32'd255);
        check("pass_after_sat", 32'(pass_cnt), 32'd0);

        // Asynchronous reset while waiting for a verdict
        done_en = 1'b0;
        send_event(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        @(posedge clk); #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valids", {30'd0, flt_valid, out_valid}, 32'd0);
        check("arst_cnts", {16'd0, pass_cnt, drop_cnt}, 32'd0);
        check("arst_flt_x", 32'(flt_x), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
